// File: rtl/immgen_pkg.sv
// Package immgen_pkg
// Purpose : shared constants for the RV32I immediate generator.
//           Format-select encodings driven by the main control and the
//           datapath width.
// Contents: XLEN, INST_W, IMM_I / IMM_LD / IMM_S / IMM_U encodings.
package immgen_pkg;

   localparam int XLEN   = 32;
   localparam int INST_W = 25;   // instruction[31:7]

   localparam logic [1:0] IMM_I  = 2'b00;  // addi / jalr
   localparam logic [1:0] IMM_LD = 2'b01;  // loads, same layout as I
   localparam logic [1:0] IMM_S  = 2'b10;  // stores
   localparam logic [1:0] IMM_U  = 2'b11;  // lui / auipc

endpackage

// File: rtl/imm_gen_if.sv
// Interface imm_gen_if
// Purpose : decode-stage bus between control/fetch logic and the immediate
//           generator.
// Signals : inst   [24:0] instruction[31:7] (inst[k] == instruction[k+7])
//           ImmSel [1:0]  immediate format select
//           immOUT [31:0] sign-extended immediate
// Modports: master - drives inst/ImmSel, receives immOUT
//           slave  - the immediate generator
interface imm_gen_if;
   import immgen_pkg::*;

   logic [INST_W-1:0] inst;
   logic [1:0]        ImmSel;
   logic [XLEN-1:0]   immOUT;

   modport master (output inst, output ImmSel, input immOUT);
   modport slave  (input inst, input ImmSel, output immOUT);

endinterface

// File: rtl/imm_decode.sv
// Module imm_decode
// Purpose : purely combinational RV32I immediate format mux.
// Ports   : inst   in  25  instruction[31:7]
//           ImmSel in  2   format select (IMM_I/IMM_LD/IMM_S/IMM_U)
//           imm    out 32  sign-extended immediate
// Index map: instruction[n] lives at inst[n-7]; the sign bit instruction[31]
// is therefore inst[24] for every format.
module imm_decode
   import immgen_pkg::*;
(
   input  logic [INST_W-1:0] inst,
   input  logic [1:0]        ImmSel,
   output logic [XLEN-1:0]   imm
);

   logic sign_bit;
   assign sign_bit = inst[24];

   always_comb begin
      // I layout is the fallback so an unknown select (R-type, don't-care)
      // still resolves to a defined mux leg.
      imm = {{20{sign_bit}}, inst[24:13]};
      case (ImmSel)
         IMM_I, IMM_LD: imm = {{20{sign_bit}}, inst[24:13]};      // i[31:20]
         IMM_S:         imm = {{20{sign_bit}}, inst[24:18], inst[4:0]}; // i[31:25], i[11:7]
         IMM_U:         imm = {inst[24:5], 12'h000};               // i[31:12]
         default:       imm = {{20{sign_bit}}, inst[24:13]};
      endcase
   end

endmodule

// File: rtl/imm_gen.sv
// Module imm_gen
// Purpose : RV32I immediate generator for the decode stage. Wraps the
//           combinational format mux with an output register (1-cycle
//           latency, updates every cycle, no enable).
// Ports   : CLK  in  1  clock, rising edge
//           RST  in  1  synchronous active-high reset (immOUT -> 0)
//           bus  slave modport of imm_gen_if (inst, ImmSel in; immOUT out)
// Config  : define IMMGEN_COMB_EN for a zero-latency combinational output;
//           CLK/RST then stay on the port list but are ignored and the
//           output has no reset value.
module imm_gen
   import immgen_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   imm_gen_if.slave   bus
);

   logic [XLEN-1:0] imm_next;

   imm_decode u_decode (
      .inst   (bus.inst),
      .ImmSel (bus.ImmSel),
      .imm    (imm_next)
   );

`ifdef IMMGEN_COMB_EN
   // Clock and reset are intentionally inert in this build.
   logic unused_clk_rst;
   assign unused_clk_rst = &{1'b0, CLK, RST};

   assign bus.immOUT = imm_next;
`else
   logic [XLEN-1:0] immout_reg;

   // Reset wins over the decode so a mid-stream pulse yields one zero sample.
   always_ff @(posedge CLK) begin
      if (RST) begin
         immout_reg <= '0;
      end else begin
         immout_reg <= imm_next;
      end
   end

   assign bus.immOUT = immout_reg;
`endif

endmodule

// File: tb/tb_imm_gen.sv
// Testbench tb_imm_gen
// Purpose : directed, table-driven check of imm_gen in registered mode
//           (default) or combinational mode (IMMGEN_COMB_EN).
module tb_imm_gen;

   logic CLK;
   logic RST;

   imm_gen_if bus ();

   imm_gen dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] instr;
      logic [1:0]  sel;
      logic [31:0] expv;
      string       name;
   } vec_t;

   vec_t vecs[12];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: immOUT=%08h expected=%08h", name, act, expv);
      end else begin
         $display("ok   %s: immOUT=%08h", name, act);
      end
   endtask

   // Inputs change on the falling edge, away from the sampling edge.
   task automatic drive(input logic [31:0] instr, input logic [1:0] sel, input logic rst);
      @(negedge CLK);
      bus.inst   = instr[31:7];
      bus.ImmSel = sel;
      RST        = rst;
   endtask

   // Registered: sample just after the capturing edge. Comb: after settle.
   task automatic sample(output logic [31:0] v);
`ifdef IMMGEN_COMB_EN
      #1;
`else
      @(posedge CLK);
      #1;
`endif
      v = bus.immOUT;
   endtask

   logic [31:0] got;

   initial begin
      vecs[0]  = '{32'h00300093, 2'b00, 32'h00000003, "addi_pos"};
      vecs[1]  = '{32'hFFF00093, 2'b00, 32'hFFFFFFFF, "addi_neg1"};
      vecs[2]  = '{32'h00812703, 2'b01, 32'h00000008, "lw_8"};
      vecs[3]  = '{32'h00E12423, 2'b10, 32'h00000008, "sw_8"};
      vecs[4]  = '{32'hFE112E23, 2'b10, 32'hFFFFFFFC, "sw_neg4"};
      vecs[5]  = '{32'h00006537, 2'b11, 32'h00006000, "lui_6"};
      vecs[6]  = '{32'h800000B7, 2'b11, 32'h80000000, "lui_msb"};
      vecs[7]  = '{32'h80000013, 2'b00, 32'hFFFFF800, "i_minval"};
      vecs[8]  = '{32'h7E000FA3, 2'b10, 32'h000007FF, "s_maxval"};
      vecs[9]  = '{32'hFFF00093, 2'b01, 32'hFFFFFFFF, "ld_neg1"};
      vecs[10] = '{32'hFFFFF037, 2'b11, 32'hFFFFF000, "u_allones"};
      vecs[11] = '{32'h00E12423, 2'b00, 32'h0000000E, "sw_as_i"};

      RST        = 1'b1;
      bus.inst   = 25'h1FFFFFF;
      bus.ImmSel = 2'b11;

`ifndef IMMGEN_COMB_EN
      // Reset held over two edges with non-zero inputs.
      @(posedge CLK); #1;
      check("reset_edge1", bus.immOUT, 32'h0);
      @(posedge CLK); #1;
      check("reset_edge2", bus.immOUT, 32'h0);
`endif

      // Back-to-back table: a new vector every cycle, each checked one edge later.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].instr, vecs[i].sel, 1'b0);
         sample(got);
         check(vecs[i].name, got, vecs[i].expv);
      end

`ifndef IMMGEN_COMB_EN
      // Reset pulse mid-stream: one zero sample, then decode of current inputs.
      drive(32'h00300093, 2'b00, 1'b0);
      sample(got);
      check("pre_rst", got, 32'h00000003);
      drive(32'hFE112E23, 2'b10, 1'b1);
      sample(got);
      check("mid_rst_zero", got, 32'h0);
      drive(32'hFE112E23, 2'b10, 1'b0);
      sample(got);
      check("post_rst", got, 32'hFFFFFFFC);

      // Output must hold the previous value until the capturing edge.
      drive(32'h00006537, 2'b11, 1'b0);
      #1;
      check("lag_before_edge", bus.immOUT, 32'hFFFFFFFC);
      sample(got);
      check("lag_after_edge", got, 32'h00006000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
